// File: rtl/priority_arbiter.sv
// Registered request arbiter with a two-state grant-hold handshake.
// Define ROUND_ROBIN_EN for rotating priority; otherwise the highest-index requester wins.
module priority_arbiter #(
  parameter  int N = 8,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] grant_idx,
  output logic [N-1:0] grant_onehot
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [W-1:0] r_grant_idx;
  logic [W-1:0] w_grant_nxt;
  logic [W-1:0] w_winner;
  logic         w_any_req;
  logic         w_sample;

  assign w_any_req = |req;
  assign w_sample  = (r_state == ST_IDLE) || ready;

`ifdef ROUND_ROBIN_EN
  logic [W-1:0] r_ptr;
  logic [W-1:0] w_ptr_nxt;
  logic         w_found;
  int           w_cand;

  // Search starts at the pointer and descends, wrapping from 0 back to N-1.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    w_winner = '0;
    w_found  = 1'b0;
    w_cand   = 0;
    for (int k = 0; k < N; k++) begin
      w_cand = (int'(r_ptr) >= k) ? (int'(r_ptr) - k) : (int'(r_ptr) - k + N);
      if (!w_found && req[w_cand]) begin
        w_winner = W'(w_cand);
        w_found  = 1'b1;
      end
    end
  end

  // The pointer moves just below each winner as it is registered, so the
  // grant loaded on this edge used the old value.
  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_sample && w_any_req) begin
      w_ptr_nxt = (w_winner == '0) ? W'(N - 1) : (w_winner - 1'b1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= W'(N - 1);
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end
`else
  // Ascending scan: the last set bit seen, i.e. the highest index, wins.
  always_comb begin
    w_winner = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        w_winner = W'(i);
      end
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant_idx;
    if (w_sample) begin
      if (w_any_req) begin
        w_state_nxt = ST_HOLD;
        w_grant_nxt = w_winner;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_grant_idx <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_state     <= w_state_nxt;
      r_grant_idx <= w_grant_nxt;
    end
  end

  // Outputs decode registers only; req and ready never reach them combinationally.
  assign valid        = (r_state == ST_HOLD);
  assign grant_idx    = r_grant_idx;
  assign grant_onehot = valid ? (N'(1) << r_grant_idx) : '0;

endmodule

// File: tb/tb_priority_arbiter.sv
// Self-checking bench for priority_arbiter: directed scenarios plus random traffic,
// two instances (N=8 and N=5) compared against a behavioural reference model.
module tb_priority_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req8;
  logic [4:0] req5;
  logic       ready;
  logic       valid8, valid5;
  logic [2:0] gidx8, gidx5;
  logic [7:0] oh8;
  logic [4:0] oh5;

  int total  = 0;
  int passed = 0;

  // Reference model state per instance
  bit mv8, mv5;
  int mi8, mi5;
  int mp8, mp5;

  logic [7:0] seq28 [8] = '{8'b00000001, 8'b00000011, 8'b00000101, 8'b00001001,
                            8'b00010001, 8'b00100001, 8'b01000001, 8'b11000001};
  int exp8 [4];
  int exp5 [6];

  always #5 clk = ~clk;

  priority_arbiter #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .req(req8), .ready(ready),
    .valid(valid8), .grant_idx(gidx8), .grant_onehot(oh8)
  );

  priority_arbiter #(.N(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .req(req5), .ready(ready),
    .valid(valid5), .grant_idx(gidx5), .grant_onehot(oh5)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Rotating priority: highest requester at or below ptr, else highest overall.
  function automatic int pick(input int n, input logic [63:0] rq, input int ptr);
`ifdef ROUND_ROBIN_EN
    for (int i = ptr; i >= 0; i--) if (rq[i]) return i;
`endif
    for (int i = n - 1; i >= 0; i--) if (rq[i]) return i;
    return 0;
  endfunction

  task automatic step_model(input int n, input logic [63:0] rq, input bit rdy,
                            inout bit mv, inout int mi, inout int mp);
    if (!mv || rdy) begin
      if (rq != 0) begin
        mi = pick(n, rq, mp);
        mv = 1'b1;
        mp = (mi == 0) ? n - 1 : mi - 1;
      end else begin
        mv = 1'b0;
      end
    end
  endtask

  task automatic reset_model();
    mv8 = 1'b0; mi8 = 0; mp8 = 7;
    mv5 = 1'b0; mi5 = 0; mp5 = 4;
  endtask

  task automatic compare_all();
    check("valid8", valid8, mv8);
    check("idx8",   gidx8,  mi8);
    check("oh8",    oh8,    mv8 ? (64'd1 << mi8) : 64'd0);
    check("valid5", valid5, mv5);
    check("idx5",   gidx5,  mi5);
    check("oh5",    oh5,    mv5 ? (64'd1 << mi5) : 64'd0);
  endtask

  task automatic cycle();
    @(posedge clk);
    step_model(8, 64'(req8), ready, mv8, mi8, mp8);
    step_model(5, 64'(req5), ready, mv5, mi5, mp5);
    #1;
    compare_all();
  endtask

  // Called just after a checked edge, so the pulse sits between clock edges.
  task automatic reset_pulse();
    #1 rst_n = 1'b0;
    reset_model();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req8  = '0;
    req5  = '0;
    ready = 1'b0;
    reset_model();
    #12;
    check("rst_valid8", valid8, 0);
    check("rst_idx8",   gidx8,  0);
    check("rst_oh8",    oh8,    0);
    check("rst_valid5", valid5, 0);
    rst_n = 1'b1;

    // Walking highest bit with ready=1
    ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      req8 = seq28[k];
      req5 = seq28[k][4:0];
      cycle();
`ifndef ROUND_ROBIN_EN
      check("walk_idx8",   gidx8,  k);
      check("walk_valid8", valid8, 1);
`endif
    end

    // Empty request after a grant
    req8 = '0;
    req5 = '0;
    cycle();
    check("empty_valid8", valid8, 0);
    check("empty_oh8",    oh8,    0);
`ifndef ROUND_ROBIN_EN
    check("empty_hold_idx8", gidx8, 7);
`endif

    // Asynchronous reset in HOLD with grant 5
    ready = 1'b0;
    req8  = 8'b00100000;
    cycle();
    check("pre_rst_idx8", gidx8, 5);
    #3 rst_n = 1'b0;
    reset_model();
    #1;
    check("async_valid8", valid8, 0);
    check("async_idx8",   gidx8,  0);
    check("async_oh8",    oh8,    0);
    req8 = '0;
    #2 rst_n = 1'b1;
    cycle();
    check("no_replay_valid8", valid8, 0);

    // Stall: request changes while held are ignored
    req8 = 8'b00100100;
    req5 = 5'b00100;
    cycle();
    for (int c = 0; c < 4; c++) begin
      if (c == 1) req8 = 8'b10000000;
      cycle();
      check("stall_idx8", gidx8, 5);
      check("stall_oh8",  oh8,   8'b00100000);
    end
    ready = 1'b1;
    cycle();
    check("stall_accept_idx8", gidx8, 7);

    // Rotation versus fixed priority with held requests
    reset_pulse();
`ifdef ROUND_ROBIN_EN
    exp8 = '{7, 0, 7, 0};
    exp5 = '{4, 3, 2, 1, 0, 4};
`else
    exp8 = '{7, 7, 7, 7};
    exp5 = '{4, 4, 4, 4, 4, 4};
`endif
    req8  = 8'b10000001;
    req5  = 5'b11111;
    ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (c < 4) check("rot_idx8", gidx8, exp8[c]);
      check("rot_idx5", gidx5, exp5[c]);
    end

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      req8  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      req5  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      ready = 1'($urandom_range(0, 1));
      cycle();
      if (c == 200) reset_pulse();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/priority_arbiter.md
PRIORITY_ARBITER -- requirements
Module: priority_arbiter

Interface
REQ-001 Parameter: N, 8, number of request lines; legal range 1..64.
REQ-002 Derived localparam: W, max(1, clog2(N)), width of the grant index.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: req  input  N  request vector; bit i set = requester i pending.
REQ-006 Port: ready  input  1  consumer accepts the current grant this cycle.
REQ-007 Port: valid  output  1  grant registers hold a valid grant.
REQ-008 Port: grant_idx  output  W  binary index of the granted requester.
REQ-009 Port: grant_onehot  output  N  one-hot form of grant_idx; all zero when valid=0.

Function
REQ-010 The block SHALL be a two-state FSM: IDLE (valid=0) and HOLD (valid=1).
REQ-011 Sample condition: state IDLE, or state HOLD with ready=1 (accept).
REQ-012 On a sample edge with req!=0, the block SHALL register the winner and enter or stay in HOLD; latency req -> valid is exactly 1 cycle.
REQ-013 On a sample edge with req==0, the block SHALL enter IDLE, drive valid=0 and grant_onehot=0, and hold grant_idx at its last value.
REQ-014 Fixed priority: the highest-index set bit of req wins (bit N-1 highest, bit 0 lowest).
REQ-015 In HOLD with ready=0, valid, grant_idx and grant_onehot SHALL stay stable, and req SHALL be ignored, including deasserted or new requests.
REQ-016 Back-to-back: an accept with req!=0 SHALL keep valid=1 and load the new grant the same edge, with no idle bubble.
REQ-017 The registered grant SHALL reflect req sampled at the sample edge only; no combinational path from req or ready to any output.
REQ-018 grant_onehot SHALL equal (1 << grant_idx) whenever valid=1.
REQ-019 N=1: grant_idx is constant 0; valid follows REQ-012/013.

Reset
REQ-020 On rst_n=0, the block SHALL immediately, asynchronously, drive state=IDLE, valid=0, grant_idx=0 and grant_onehot=0, and set the rotation pointer (if present) to N-1.
REQ-021 Reset asserted in HOLD SHALL discard the pending grant; no grant is re-presented after release.
REQ-022 The first sample edge after rst_n rises SHALL behave as an IDLE sample.

Configuration
REQ-023 Macro ROUND_ROBIN_EN: when defined, the block SHALL use rotating priority; when undefined, fixed priority per REQ-014 with no pointer register.
REQ-024 With ROUND_ROBIN_EN, a W-bit pointer ptr (reset N-1) SHALL set the search order: start at ptr, then descend through lower indices, wrapping from 0 to N-1.
REQ-025 With ROUND_ROBIN_EN, on each accepted grant g, the block SHALL update ptr to g-1, or to N-1 if g=0; ptr SHALL be unchanged when there is no accept.
REQ-026 Grant loading on the accept edge (REQ-016) SHALL use the pre-update ptr; the updated ptr applies from the next sample onward.

Verification
REQ-027 Reset: drive rst_n=0 mid-HOLD with grant_idx=5 -> valid=0, grant_idx=0 and grant_onehot=0 immediately, without waiting for a clk edge.
REQ-028 Fixed N=8, ready=1, req sequence 00000001, 00000011, 00000101, 00001001, 00010001, 00100001, 01000001, 11000001 -> grant_idx one cycle later is 0, 1, 2, 3, 4, 5, 6, 7, with valid=1 throughout.
REQ-029 Stall: req=00100100, ready=0 for 4 cycles, req changed to 10000000 in cycle 2 -> grant_idx=5 and grant_onehot=00100000 stable for all 4 cycles; first accept loads 7.
REQ-030 Empty: req=0 with ready=1 after a grant -> valid=0 next cycle, grant_onehot=0, grant_idx holds its last value.
REQ-031 ROUND_ROBIN_EN, N=8: req=10000001 held, ready=1 -> grants 7, 0, 7, 0; same stimulus without the macro -> grants 7, 7, 7, 7.
REQ-032 N=5, ROUND_ROBIN_EN: req=11111 held, ready=1 -> grants 4, 3, 2, 1, 0, 4; W=3 and grant_idx never exceeds 4.
